prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader.sv | 189 ++++++++++++++++++
 tb/tb_prog_loader.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// prog_loader: parses a word stream of load blocks and writes them into the
// CPU instruction memory (32-bit port) or data memory (64-bit port), then
// releases the CPU. Optional build macro LOADER_CHECKSUM_EN adds a trailer
// word that must equal the 32-bit sum of all payload beats since reset.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_HDR     | waiting for a block header word
// S_ADDR    | waiting for the block base byte-address word
// S_IMEM    | accepting instruction words, one write per beat
// S_DMEM_LO | accepting low half of a 64-bit data word
// S_DMEM_HI | accepting high half, one 64-bit write per pair
// S_CSUM    | (checksum build only) accepting the checksum trailer
// S_RUN     | load finished, CPU released unless an error was seen
module prog_loader (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic [63:0] addr_ext,
  output logic        wen_ext,
  output logic        ren_ext,
  output logic [31:0] wdata_ext,
  output logic [63:0] addr_ext_2,
  output logic        wen_ext_2,
  output logic        ren_ext_2,
  output logic [63:0] wdata_ext_2,
  output logic        cpu_enable,
  output logic        busy,
  output logic        error
);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_HDR, S_ADDR, S_IMEM, S_DMEM_LO, S_DMEM_HI, S_CSUM, S_RUN
  } state_t;
  localparam state_t END_STATE = S_CSUM;
`else
  typedef enum logic [2:0] {
    S_HDR, S_ADDR, S_IMEM, S_DMEM_LO, S_DMEM_HI, S_RUN
  } state_t;
  localparam state_t END_STATE = S_RUN;
`endif

  state_t      r_state;
  state_t      w_state_next;
  logic        w_fire;
  logic        w_last_word;
  logic        w_misalign;

  logic        r_target;   // 0 = imem, 1 = dmem
  logic        r_last;
  logic [15:0] r_remain;   // payload words still to come in this block
  logic [63:0] r_ptr;      // next write byte address
  logic        r_skip;     // misaligned block: consume payload, no writes
  logic [31:0] r_lo;
  logic        r_wen;
  logic [63:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_wen2;
  logic [63:0] r_addr2;
  logic [63:0] r_wdata2;
  logic        r_cpu_en;
  logic        r_error;

  assign w_fire      = in_valid && in_ready;
  assign w_last_word = (r_remain == 16'd1);
  assign w_misalign  = r_target ? (in_data[2:0] != 3'b000) : (in_data[1:0] != 2'b00);

  assign in_ready    = (r_state != S_RUN);
  assign addr_ext    = r_addr;
  assign wen_ext     = r_wen;
  assign ren_ext     = 1'b0;
  assign wdata_ext   = r_wdata;
  assign addr_ext_2  = r_addr2;
  assign wen_ext_2   = r_wen2;
  assign ren_ext_2   = 1'b0;
  assign wdata_ext_2 = r_wdata2;
  assign cpu_enable  = r_cpu_en;
  assign error       = r_error;
  // Busy covers the block body plus the cycle its final strobe is on the bus.
  assign busy = (r_state == S_ADDR) || (r_state == S_IMEM) ||
                (r_state == S_DMEM_LO) || (r_state == S_DMEM_HI) ||
                r_wen || r_wen2;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_HDR;
    else     r_state <= w_state_next;
  end

  // Next-state decode; only accepted beats move the parser.
  always_comb begin
    w_state_next = r_state;
    if (w_fire) begin
      case (r_state)
        S_HDR:     w_state_next = S_ADDR;
        S_ADDR: begin
          if (r_remain == 16'd0) w_state_next = r_last ? END_STATE : S_HDR;
          else                   w_state_next = r_target ? S_DMEM_LO : S_IMEM;
        end
        S_IMEM:    if (w_last_word) w_state_next = r_last ? END_STATE : S_HDR;
        S_DMEM_LO: w_state_next = S_DMEM_HI;
        S_DMEM_HI: w_state_next = w_last_word ? (r_last ? END_STATE : S_HDR) : S_DMEM_LO;
`ifdef LOADER_CHECKSUM_EN
        S_CSUM:    w_state_next = S_RUN;
`endif
        default:   w_state_next = r_state;
      endcase
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [31:0] r_csum;
  logic        w_payload_beat;
  assign w_payload_beat = w_fire && ((r_state == S_IMEM) || (r_state == S_DMEM_LO) ||
                                     (r_state == S_DMEM_HI));

  // Running sum of every payload beat since reset, discarded blocks included.
  always_ff @(posedge clk) begin
    if (rst)                 r_csum <= 32'd0;
    else if (w_payload_beat) r_csum <= r_csum + in_data;
  end
`endif

  // Block bookkeeping, write strobes, error flag and CPU release.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_target <= 1'b0;
      r_last   <= 1'b0;
      r_remain <= 16'd0;
      r_ptr    <= 64'd0;
      r_skip   <= 1'b0;
      r_lo     <= 32'd0;
      r_wen    <= 1'b0;
      r_addr   <= 64'd0;
      r_wdata  <= 32'd0;
      r_wen2   <= 1'b0;
      r_addr2  <= 64'd0;
      r_wdata2 <= 64'd0;
      r_cpu_en <= 1'b0;
      r_error  <= 1'b0;
    end else begin
      r_wen  <= 1'b0;
      r_wen2 <= 1'b0;
      // Registered so release lands the cycle after the final strobe.
      r_cpu_en <= (r_state == S_RUN) && !r_error;
      if (w_fire) begin
        case (r_state)
          S_HDR: begin
            r_target <= in_data[31];
            r_last   <= in_data[30];
            r_remain <= in_data[15:0];
          end
          S_ADDR: begin
            r_ptr  <= {32'd0, in_data};
            r_skip <= w_misalign;
            if (w_misalign) r_error <= 1'b1;
          end
          S_IMEM: begin
            if (!r_skip) begin
              r_wen   <= 1'b1;
              r_addr  <= r_ptr;
              r_wdata <= in_data;
            end
            r_ptr    <= r_ptr + 64'd4;
            r_remain <= r_remain - 16'd1;
          end
          S_DMEM_LO: r_lo <= in_data;
          S_DMEM_HI: begin
            if (!r_skip) begin
              r_wen2   <= 1'b1;
              r_addr2  <= r_ptr;
              r_wdata2 <= {in_data, r_lo};
            end
            r_ptr    <= r_ptr + 64'd8;
            r_remain <= r_remain - 16'd1;
          end
`ifdef LOADER_CHECKSUM_EN
          S_CSUM: if (in_data != r_csum) r_error <= 1'b1;
`endif
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: imem/dmem blocks, idle gaps, misaligned
// base, address wrap past 32 bits, mid-block reset and the empty last block.
module tb_prog_loader;
  logic        clk, rst, in_valid, in_ready;
  logic [31:0] in_data;
  logic [63:0] addr_ext, addr_ext_2, wdata_ext_2;
  logic        wen_ext, ren_ext, wen_ext_2, ren_ext_2;
  logic [31:0] wdata_ext;
  logic        cpu_enable, busy, error;

  int errors = 0;
  int checks = 0;
  int overlap_cnt = 0;
  int ren_cnt = 0;
  logic [31:0] tb_sum;

  logic [63:0] q_addr[$];
  logic [31:0] q_data[$];
  logic [63:0] q2_addr[$];
  logic [63:0] q2_data[$];

  prog_loader dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext), .wdata_ext(wdata_ext),
    .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2), .ren_ext_2(ren_ext_2),
    .wdata_ext_2(wdata_ext_2), .cpu_enable(cpu_enable), .busy(busy), .error(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every strobe cycle and watch for strobe/enable overlap.
  always @(negedge clk) begin
    if (wen_ext === 1'b1) begin q_addr.push_back(addr_ext); q_data.push_back(wdata_ext); end
    if (wen_ext_2 === 1'b1) begin q2_addr.push_back(addr_ext_2); q2_data.push_back(wdata_ext_2); end
    if (cpu_enable === 1'b1 && (wen_ext === 1'b1 || wen_ext_2 === 1'b1)) overlap_cnt++;
    if (ren_ext !== 1'b0 || ren_ext_2 !== 1'b0) ren_cnt++;
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_pl(input logic [31:0] d);
    tb_sum = tb_sum + d;
    send(d);
  endtask

  task automatic send_trailer();
`ifdef LOADER_CHECKSUM_EN
    send(tb_sum);
`endif
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(1);
    q_addr.delete(); q_data.delete(); q2_addr.delete(); q2_data.delete();
    tb_sum = 32'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = 32'd0;
    idle(2);
    checks++;
    if ({in_ready, wen_ext, wen_ext_2, cpu_enable, busy, error} !== 6'b100000) begin
      errors++; $display("FAIL reset_hold flags got %b want 100000",
                         {in_ready, wen_ext, wen_ext_2, cpu_enable, busy, error});
    end
    checks++;
    if (addr_ext !== 64'd0 || wdata_ext !== 32'd0 || addr_ext_2 !== 64'd0 || wdata_ext_2 !== 64'd0) begin
      errors++; $display("FAIL reset_buses got %h %h %h %h want zeros", addr_ext, wdata_ext, addr_ext_2, wdata_ext_2);
    end
    rst = 1'b0;
    idle(1);
    checks++;
    if ({in_ready, wen_ext, wen_ext_2, cpu_enable, busy, error} !== 6'b100000) begin
      errors++; $display("FAIL reset_release flags got %b want 100000",
                         {in_ready, wen_ext, wen_ext_2, cpu_enable, busy, error});
    end
    q_addr.delete(); q_data.delete(); q2_addr.delete(); q2_data.delete();
    tb_sum = 32'd0;
  endtask

  task automatic test_imem();
    send(32'h0000_0002);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL imem_busy_addr got %b want 1", busy); end
    send(32'h0);
    send_pl(32'h0050_0093);
    checks++;
    if (wen_ext !== 1'b1 || addr_ext !== 64'h0 || wdata_ext !== 32'h0050_0093) begin
      errors++; $display("FAIL imem_first_strobe got wen=%b a=%h d=%h want 1 0 00500093", wen_ext, addr_ext, wdata_ext);
    end
    send_pl(32'h0010_0113);
    checks++;
    if (wen_ext !== 1'b1 || addr_ext !== 64'h4 || wdata_ext !== 32'h0010_0113) begin
      errors++; $display("FAIL imem_second_strobe got wen=%b a=%h d=%h want 1 4 00100113", wen_ext, addr_ext, wdata_ext);
    end
    idle(2);
    checks++;
    if (q_addr.size() != 2 || q2_addr.size() != 0) begin
      errors++; $display("FAIL imem_strobe_count got %0d/%0d want 2/0", q_addr.size(), q2_addr.size());
    end else begin
      checks++;
      if (q_addr[0] !== 64'h0 || q_data[0] !== 32'h0050_0093 || q_addr[1] !== 64'h4 || q_data[1] !== 32'h0010_0113) begin
        errors++; $display("FAIL imem_log got %h:%h %h:%h", q_addr[0], q_data[0], q_addr[1], q_data[1]);
      end
    end
    checks++;
    if (cpu_enable !== 1'b0 || busy !== 1'b0 || error !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL imem_after got cpu=%b busy=%b err=%b rdy=%b want 0 0 0 1", cpu_enable, busy, error, in_ready);
    end
  endtask

  task automatic test_wrap();
    q_addr.delete(); q_data.delete();
    send(32'h0000_0002); send(32'hFFFF_FFFC);
    send_pl(32'hAAAA_0001); send_pl(32'hAAAA_0002);
    idle(2);
    checks++;
    if (q_addr.size() != 2) begin
      errors++; $display("FAIL wrap_count got %0d want 2", q_addr.size());
    end else begin
      checks++;
      if (q_addr[0] !== 64'h0000_0000_FFFF_FFFC || q_addr[1] !== 64'h0000_0001_0000_0000) begin
        errors++; $display("FAIL wrap_addr got %h %h want 00000000fffffffc 0000000100000000", q_addr[0], q_addr[1]);
      end
    end
  endtask

  task automatic test_idle_gaps();
    q_addr.delete(); q_data.delete();
    send(32'h0000_0001);
    idle(3);
    send(32'h0000_0100);
    idle(2);
    checks++;
    if (q_addr.size() != 0 || busy !== 1'b1) begin
      errors++; $display("FAIL gap_no_strobe got n=%0d busy=%b want 0 1", q_addr.size(), busy);
    end
    send_pl(32'hDEAD_BEEF);
    idle(2);
    checks++;
    if (q_addr.size() != 1) begin
      errors++; $display("FAIL gap_count got %0d want 1", q_addr.size());
    end else begin
      checks++;
      if (q_addr[0] !== 64'h100 || q_data[0] !== 32'hDEAD_BEEF) begin
        errors++; $display("FAIL gap_write got %h:%h want 100:deadbeef", q_addr[0], q_data[0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    send(32'h0000_0000); send(32'h0);
    send(32'h8000_0002); send(32'h0000_0100);
    send_pl(32'hA0A0_A0A0); send_pl(32'hB0B0_B0B0);
    send_pl(32'hC0C0_C0C0); send_pl(32'hD0D0_D0D0);
    send(32'h0000_0001); send(32'h0000_0200); send_pl(32'h7777_7777);
    idle(2);
    checks++;
    if (q2_addr.size() != 2 || q_addr.size() != 1) begin
      errors++; $display("FAIL b2b_count got d=%0d i=%0d want 2 1", q2_addr.size(), q_addr.size());
    end else begin
      checks++;
      if (q2_addr[0] !== 64'h100 || q2_data[0] !== 64'hB0B0B0B0_A0A0A0A0 ||
          q2_addr[1] !== 64'h108 || q2_data[1] !== 64'hD0D0D0D0_C0C0C0C0) begin
        errors++; $display("FAIL b2b_dmem got %h:%h %h:%h", q2_addr[0], q2_data[0], q2_addr[1], q2_data[1]);
      end
      checks++;
      if (q_addr[0] !== 64'h200 || q_data[0] !== 32'h7777_7777) begin
        errors++; $display("FAIL b2b_imem got %h:%h want 200:77777777", q_addr[0], q_data[0]);
      end
    end
    checks++;
    if (error !== 1'b0 || cpu_enable !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL b2b_flags got err=%b cpu=%b busy=%b want 0 0 0", error, cpu_enable, busy);
    end
  endtask

  task automatic test_dmem_last();
    do_reset();
    send(32'hC000_0001); send(32'h0000_0010);
    send_pl(32'h1111_1111); send_pl(32'h2222_2222);
    checks++;
    if (wen_ext_2 !== 1'b1 || addr_ext_2 !== 64'h10 || wdata_ext_2 !== 64'h22222222_11111111 || cpu_enable !== 1'b0) begin
      errors++; $display("FAIL dmem_strobe got wen=%b a=%h d=%h cpu=%b want 1 10 2222222211111111 0",
                         wen_ext_2, addr_ext_2, wdata_ext_2, cpu_enable);
    end
    send_trailer();
    checks++;
    if (cpu_enable !== 1'b0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL dmem_run_entry got cpu=%b rdy=%b want 0 0", cpu_enable, in_ready);
    end
    idle(1);
    checks++;
    if (cpu_enable !== 1'b1 || wen_ext_2 !== 1'b0 || error !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL dmem_release got cpu=%b wen2=%b err=%b busy=%b want 1 0 0 0", cpu_enable, wen_ext_2, error, busy);
    end
    checks++;
    if (q2_addr.size() != 1 || q_addr.size() != 0) begin
      errors++; $display("FAIL dmem_count got d=%0d i=%0d want 1 0", q2_addr.size(), q_addr.size());
    end
  endtask

  task automatic test_misaligned();
    do_reset();
    send(32'h0000_0001); send(32'h0000_0002);
    checks++;
    if (error !== 1'b1) begin errors++; $display("FAIL misalign_err got %b want 1", error); end
    send_pl(32'h1234_5678);
    send(32'h8000_0001); send(32'h0000_0004);
    send_pl(32'h0000_0011); send_pl(32'h0000_0022);
    idle(2);
    checks++;
    if (q_addr.size() != 0 || q2_addr.size() != 0) begin
      errors++; $display("FAIL misalign_discard got i=%0d d=%0d want 0 0", q_addr.size(), q2_addr.size());
    end
    send(32'h0000_0001); send(32'h0000_0020); send_pl(32'hAAAA_5555);
    idle(2);
    checks++;
    if (q_addr.size() != 1) begin
      errors++; $display("FAIL misalign_next_count got %0d want 1", q_addr.size());
    end else begin
      checks++;
      if (q_addr[0] !== 64'h20 || q_data[0] !== 32'hAAAA_5555) begin
        errors++; $display("FAIL misalign_next_write got %h:%h want 20:aaaa5555", q_addr[0], q_data[0]);
      end
    end
    send(32'h4000_0000); send(32'h0);
    send_trailer();
    idle(4);
    checks++;
    if (in_ready !== 1'b0 || cpu_enable !== 1'b0 || error !== 1'b1) begin
      errors++; $display("FAIL misalign_run got rdy=%b cpu=%b err=%b want 0 0 1", in_ready, cpu_enable, error);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    send(32'h0000_0004); send(32'h0000_0040);
    send_pl(32'h0000_0A01); send_pl(32'h0000_0A02);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    checks++;
    if ({in_ready, wen_ext, wen_ext_2, cpu_enable, busy, error} !== 6'b100000 || addr_ext !== 64'd0) begin
      errors++; $display("FAIL midrst_outputs got %b a=%h want 100000 0",
                         {in_ready, wen_ext, wen_ext_2, cpu_enable, busy, error}, addr_ext);
    end
    idle(1);
    checks++;
    if ({in_ready, wen_ext, busy} !== 3'b100) begin
      errors++; $display("FAIL midrst_release got %b want 100", {in_ready, wen_ext, busy});
    end
    checks++;
    if (q_addr.size() != 2) begin errors++; $display("FAIL midrst_count got %0d want 2", q_addr.size()); end
    tb_sum = 32'd0;
    send(32'h0000_0001); send(32'h0000_0080); send_pl(32'h0000_0055);
    idle(2);
    checks++;
    if (q_addr.size() != 3) begin
      errors++; $display("FAIL midrst_header_count got %0d want 3", q_addr.size());
    end else begin
      checks++;
      if (q_addr[2] !== 64'h80 || q_data[2] !== 32'h55) begin
        errors++; $display("FAIL midrst_header_write got %h:%h want 80:55", q_addr[2], q_data[2]);
      end
    end
  endtask

  task automatic test_run_empty();
    do_reset();
    send(32'h4000_0000); send(32'h0);
    send_trailer();
    checks++;
    if (in_ready !== 1'b0 || cpu_enable !== 1'b0) begin
      errors++; $display("FAIL empty_entry got rdy=%b cpu=%b want 0 0", in_ready, cpu_enable);
    end
    idle(1);
    checks++;
    if (cpu_enable !== 1'b1 || error !== 1'b0) begin
      errors++; $display("FAIL empty_release got cpu=%b err=%b want 1 0", cpu_enable, error);
    end
    in_valid = 1'b1; in_data = 32'h0000_0001;
    idle(4);
    in_valid = 1'b0;
    idle(2);
    checks++;
    if (cpu_enable !== 1'b1 || in_ready !== 1'b0 || q_addr.size() != 0 || q2_addr.size() != 0) begin
      errors++; $display("FAIL empty_stay_run got cpu=%b rdy=%b i=%0d d=%0d want 1 0 0 0",
                         cpu_enable, in_ready, q_addr.size(), q2_addr.size());
    end
  endtask

  task automatic test_invariants();
    checks++;
    if (overlap_cnt != 0) begin errors++; $display("FAIL strobe_enable_overlap got %0d want 0", overlap_cnt); end
    checks++;
    if (ren_cnt != 0) begin errors++; $display("FAIL ren_nonzero got %0d want 0", ren_cnt); end
  endtask

  initial begin
    in_valid = 1'b0; in_data = 32'd0; rst = 1'b1; tb_sum = 32'd0;
    test_reset();
    test_imem();
    test_wrap();
    test_idle_gaps();
    test_back_to_back();
    test_dmem_last();
    test_misaligned();
    test_reset_mid();
    test_run_empty();
    test_invariants();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
